hdc_dataset_sequencer: RTL and testbench
========================================

Name: hdc_dataset_sequencer

Overview:
- Host-side initiator for the one-shot HDC top. Accepts a word-serial feature stream with labels.
- Assembles each sample into a FEATURE_COUNT x 16-bit parallel vector and drives the top's training and testing protocol: start_hdc, start_mapping, class_select_bits, training_dataset_finished, start_binarizing, testing_dataset_finished.
- Consumes the top's class_inference and checking_inference to tally test accuracy.
- Sits between the dataset memory/DMA and the HDC top.

Parameters:
FEATURE_COUNT, 617, features per sample
WORD_W, 16, feature word width
CLASS_W, 5, label/class index width
NUM_CLASSES, 26, valid labels 0..NUM_CLASSES-1
CNT_W, 16, sample counter width
BIN_WAIT, 4, cycles held in BIN_WAIT after start_binarizing before testing begins
TIMEOUT, 65535, watchdog limit (optional feature only)

Ports:
clk  in  1  clock
nrst  in  1  reset, synchronous, active-high: 1 = reset (name per codebase; polarity and synchronicity fixed)
go  in  1  start a full train+test run; ignored unless IDLE/DONE
n_train  in  CNT_W  training sample count, latched on go
n_test  in  CNT_W  testing sample count, latched on go
s_valid  in  1  stream word valid
s_ready  out  1  stream word accepted when s_valid&s_ready
s_data  in  WORD_W  feature word
s_label  in  CLASS_W  sample label, sampled with first word of sample
s_last  in  1  last word of sample
start_hdc  out  1  one-cycle pulse to top FSM
start_mapping  out  1  one-cycle pulse per sample
input_values  out  WORD_W x FEATURE_COUNT  assembled sample, held stable until next LOAD
class_select_bits  out  CLASS_W  current training label
training_dataset_finished  out  1  level, set from TRAIN_END until IDLE
start_binarizing  out  1  one-cycle pulse
testing_dataset_finished  out  1  level, set from FINISH until IDLE
class_gen_done  in  1  training sample absorbed
checking_inference  in  1  class_inference valid this cycle
class_inference  in  CLASS_W  predicted class
oneshot_hdc_done  in  1  top finished
busy  out  1  not IDLE/DONE
done  out  1  level in DONE
correct_count  out  CNT_W  test hits
label_err  out  1  sticky: label >= NUM_CLASSES seen
len_err  out  1  sticky: sample length != FEATURE_COUNT

Behaviour:
- Reset: all outputs 0, input_values all 0, counters 0, state IDLE. Reset asserted mid-run aborts immediately to IDLE next edge; no protocol pulses are emitted.
- FSM states and transitions:
  - IDLE/DONE --go--> START. Latch n_train/n_test, clear correct_count, label_err, len_err.
  - START: pulse start_hdc. Go to TRAIN_END if n_train==0, else LOAD.
  - LOAD: s_ready=1. Word k writes input_values[k]. Index wraps only at sample end.
    - Words beyond FEATURE_COUNT-1 are dropped and set len_err.
    - s_last before FEATURE_COUNT words: remaining entries zeroed, len_err set.
    - Accepting s_last goes to MAP.
  - MAP: pulse start_mapping. For training, class_select_bits=latched label. Go to WAIT_TRAIN or WAIT_INF.
  - WAIT_TRAIN: wait class_gen_done. Increment train count. Go to TRAIN_END when count==n_train, else LOAD.
  - TRAIN_END: set training_dataset_finished; pulse start_binarizing; go to BIN_WAIT.
  - BIN_WAIT: BIN_WAIT cycles. Go to FINISH if n_test==0, else LOAD (test phase).
  - WAIT_INF: on checking_inference, correct_count += (class_inference==label); saturates at all-ones. Go to FINISH at n_test, else LOAD.
  - FINISH: set testing_dataset_finished; wait oneshot_hdc_done -> DONE.
- Latency: start_mapping asserts exactly 1 cycle after the s_last handshake. input_values is stable on and after that cycle.
- Labels >= NUM_CLASSES are forwarded unchanged and set label_err.
- checking_inference and class_gen_done are ignored outside their wait states.
- s_ready=0 outside LOAD.

Optional Feature:
- Macro: HDC_SEQ_TIMEOUT_EN.
- Defined: a per-wait-state counter runs in WAIT_TRAIN, WAIT_INF and FINISH. When it reaches TIMEOUT, the block adds output timeout_err (sticky), goes to DONE, and asserts done.
- Undefined: no counter, no timeout_err port; wait states wait forever.

Test Plan:
- n_train=2, n_test=1, full 617-word samples, labels 3,7, test label 7, model returns 7 -> one start_hdc, three start_mapping, class_select_bits 3 then 7, start_binarizing once, correct_count=1, done=1, no errors.
- Test label 4, model returns 9 -> correct_count=0.
- Sample with s_last at word 600 -> input_values[600..616]=0, len_err=1. Next sample of 620 words -> words 617..619 dropped, run continues.
- n_train=0, n_test=0 -> START, TRAIN_END, BIN_WAIT (4 cycles), FINISH; done after oneshot_hdc_done; zero start_mapping pulses.
- nrst=1 asserted in WAIT_INF -> next cycle all outputs 0, busy=0. A new go then runs a clean pass.
- With HDC_SEQ_TIMEOUT_EN and TIMEOUT=16: withhold class_gen_done -> timeout_err=1, done=1 after 16 cycles.

Source files
------------

// File: rtl/hdc_dataset_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : hdc_dataset_sequencer_if
// Brief    : Word-serial feature stream carrying one sample per s_last-framed
//            burst. The label travels with the first word of each sample.
// Revision : 1.0 - initial release
// ============================================================================
interface hdc_dataset_sequencer_if #(
  parameter int WORD_W  = 16,
  parameter int CLASS_W = 5
);
  logic               s_valid;
  logic               s_ready;
  logic [WORD_W-1:0]  s_data;
  logic [CLASS_W-1:0] s_label;
  logic               s_last;

  // Dataset memory / DMA side
  modport master (
    output s_valid, s_data, s_label, s_last,
    input  s_ready
  );

  // Sequencer side
  modport slave (
    input  s_valid, s_data, s_label, s_last,
    output s_ready
  );
endinterface
`default_nettype wire

// File: rtl/hdc_dataset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : hdc_dataset_sequencer
// Brief    : Host-side initiator for the one-shot HDC top. Assembles streamed
//            samples into a parallel feature vector, sequences the training
//            and testing protocol and tallies correct test inferences.
//            Optional watchdog on the wait states: HDC_SEQ_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hdc_dataset_sequencer #(
  parameter int FEATURE_COUNT = 617,
  parameter int WORD_W        = 16,
  parameter int CLASS_W       = 5,
  parameter int NUM_CLASSES   = 26,
  parameter int CNT_W         = 16,
  parameter int BIN_WAIT      = 4
`ifdef HDC_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT     = 65535
`endif
) (
  input  logic                            clk,
  input  logic                            nrst,
  input  logic                            go,
  input  logic [CNT_W-1:0]                n_train,
  input  logic [CNT_W-1:0]                n_test,
  hdc_dataset_sequencer_if.slave          strm,
  output logic                            start_hdc,
  output logic                            start_mapping,
  output logic [WORD_W*FEATURE_COUNT-1:0] input_values,
  output logic [CLASS_W-1:0]              class_select_bits,
  output logic                            training_dataset_finished,
  output logic                            start_binarizing,
  output logic                            testing_dataset_finished,
  input  logic                            class_gen_done,
  input  logic                            checking_inference,
  input  logic [CLASS_W-1:0]              class_inference,
  input  logic                            oneshot_hdc_done,
  output logic                            busy,
  output logic                            done,
  output logic [CNT_W-1:0]                correct_count,
  output logic                            label_err,
  output logic                            len_err
`ifdef HDC_SEQ_TIMEOUT_EN
  , output logic                          timeout_err
`endif
);

  localparam int IDX_W = $clog2(FEATURE_COUNT + 1);
  localparam int BW_W  = $clog2(BIN_WAIT) + 1;

  localparam logic [IDX_W-1:0]   c_fc          = IDX_W'(FEATURE_COUNT);
  localparam logic [IDX_W-1:0]   c_fc_m1       = IDX_W'(FEATURE_COUNT - 1);
  localparam logic [BW_W-1:0]    c_bin_last    = BW_W'(BIN_WAIT - 1);
  localparam logic [CLASS_W:0]   c_num_classes = (CLASS_W+1)'(NUM_CLASSES);

  localparam logic [3:0] c_st_idle       = 4'd0;
  localparam logic [3:0] c_st_start      = 4'd1;
  localparam logic [3:0] c_st_load       = 4'd2;
  localparam logic [3:0] c_st_map        = 4'd3;
  localparam logic [3:0] c_st_wait_train = 4'd4;
  localparam logic [3:0] c_st_train_end  = 4'd5;
  localparam logic [3:0] c_st_bin_wait   = 4'd6;
  localparam logic [3:0] c_st_wait_inf   = 4'd7;
  localparam logic [3:0] c_st_finish     = 4'd8;
  localparam logic [3:0] c_st_done       = 4'd9;

  logic [3:0]         r_state;
  logic [3:0]         w_state_nx;

  logic [WORD_W-1:0]  r_vals [FEATURE_COUNT];
  logic [IDX_W-1:0]   r_idx;
  logic [CLASS_W-1:0] r_label;
  logic [CLASS_W-1:0] r_class_sel;
  logic [CNT_W-1:0]   r_n_train;
  logic [CNT_W-1:0]   r_n_test;
  logic [CNT_W-1:0]   r_train_cnt;
  logic [CNT_W-1:0]   r_test_cnt;
  logic [CNT_W-1:0]   r_correct;
  logic [BW_W-1:0]    r_bin_cnt;
  logic               r_test_phase;
  logic               r_train_fin;
  logic               r_test_fin;
  logic               r_label_err;
  logic               r_len_err;

  logic               w_go_ok;
  logic               w_hs;
  logic [CLASS_W-1:0] w_label_now;
  logic [CNT_W-1:0]   w_train_nx;
  logic [CNT_W-1:0]   w_test_nx;

  assign w_go_ok     = go && (r_state == c_st_idle || r_state == c_st_done);
  assign w_hs        = strm.s_valid && (r_state == c_st_load);
  // A one-word sample carries its label on the same beat as s_last
  assign w_label_now = (r_idx == '0) ? strm.s_label : r_label;
  assign w_train_nx  = r_train_cnt + 1'b1;
  assign w_test_nx   = r_test_cnt + 1'b1;

`ifdef HDC_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] c_to_last = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] r_wait_cnt;
  logic            r_timeout_err;
  logic            w_in_wait;
  logic            w_wait_event;
  logic            w_timeout;

  assign w_in_wait    = (r_state == c_st_wait_train) || (r_state == c_st_wait_inf) ||
                        (r_state == c_st_finish);
  assign w_wait_event = ((r_state == c_st_wait_train) && class_gen_done) ||
                        ((r_state == c_st_wait_inf) && checking_inference) ||
                        ((r_state == c_st_finish) && oneshot_hdc_done);
  assign w_timeout    = w_in_wait && !w_wait_event && (r_wait_cnt == c_to_last);
  assign timeout_err  = r_timeout_err;

  // Watchdog: restarts on every state change, counts only while waiting
  always_ff @(posedge clk) begin
    if (nrst) begin
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state != w_state_nx)
        r_wait_cnt <= '0;
      else if (w_in_wait)
        r_wait_cnt <= r_wait_cnt + 1'b1;
      if (w_go_ok)
        r_timeout_err <= 1'b0;
      else if (w_timeout)
        r_timeout_err <= 1'b1;
    end
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (nrst) r_state <= c_st_idle;
    else      r_state <= w_state_nx;
  end

  // Next-state decode
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      c_st_idle, c_st_done:
        if (go) w_state_nx = c_st_start;
      c_st_start:
        w_state_nx = (r_n_train == '0) ? c_st_train_end : c_st_load;
      c_st_load:
        if (w_hs && strm.s_last) w_state_nx = c_st_map;
      c_st_map:
        w_state_nx = r_test_phase ? c_st_wait_inf : c_st_wait_train;
      c_st_wait_train:
        if (class_gen_done)
          w_state_nx = (w_train_nx == r_n_train) ? c_st_train_end : c_st_load;
      c_st_train_end:
        w_state_nx = c_st_bin_wait;
      c_st_bin_wait:
        if (r_bin_cnt == c_bin_last)
          w_state_nx = (r_n_test == '0) ? c_st_finish : c_st_load;
      c_st_wait_inf:
        if (checking_inference)
          w_state_nx = (w_test_nx == r_n_test) ? c_st_finish : c_st_load;
      c_st_finish:
        if (oneshot_hdc_done) w_state_nx = c_st_done;
      default:
        w_state_nx = c_st_idle;
    endcase
`ifdef HDC_SEQ_TIMEOUT_EN
    if (w_timeout) w_state_nx = c_st_done;
`endif
  end

  // Protocol outputs decoded from the current state
  always_comb begin
    strm.s_ready              = (r_state == c_st_load);
    start_hdc                 = (r_state == c_st_start);
    start_mapping             = (r_state == c_st_map);
    start_binarizing          = (r_state == c_st_train_end);
    training_dataset_finished = r_train_fin || (r_state == c_st_train_end);
    testing_dataset_finished  = r_test_fin || (r_state == c_st_finish);
    busy                      = (r_state != c_st_idle) && (r_state != c_st_done);
    done                      = (r_state == c_st_done);
  end

  // Sample assembly, run bookkeeping and accuracy tally
  always_ff @(posedge clk) begin
    if (nrst) begin
      for (int j = 0; j < FEATURE_COUNT; j++) r_vals[j] <= '0;
      r_idx        <= '0;
      r_label      <= '0;
      r_class_sel  <= '0;
      r_n_train    <= '0;
      r_n_test     <= '0;
      r_train_cnt  <= '0;
      r_test_cnt   <= '0;
      r_correct    <= '0;
      r_bin_cnt    <= '0;
      r_test_phase <= 1'b0;
      r_train_fin  <= 1'b0;
      r_test_fin   <= 1'b0;
      r_label_err  <= 1'b0;
      r_len_err    <= 1'b0;
    end else begin
      if (w_go_ok) begin
        r_n_train    <= n_train;
        r_n_test     <= n_test;
        r_train_cnt  <= '0;
        r_test_cnt   <= '0;
        r_correct    <= '0;
        r_idx        <= '0;
        r_test_phase <= 1'b0;
        r_train_fin  <= 1'b0;
        r_test_fin   <= 1'b0;
        r_label_err  <= 1'b0;
        r_len_err    <= 1'b0;
      end

      if (w_hs) begin
        if (r_idx == '0) begin
          r_label <= strm.s_label;
          if ({1'b0, strm.s_label} >= c_num_classes) r_label_err <= 1'b1;
        end
        // Overlong samples: excess words are discarded
        if (r_idx < c_fc) r_vals[r_idx] <= strm.s_data;
        else              r_len_err <= 1'b1;
        if (strm.s_last) begin
          r_idx <= '0;
          if (!r_test_phase) r_class_sel <= w_label_now;
          // Short sample: clear the tail so no stale features leak through
          if (r_idx < c_fc_m1) begin
            r_len_err <= 1'b1;
            for (int j = 0; j < FEATURE_COUNT; j++)
              if (IDX_W'(j) > r_idx) r_vals[j] <= '0;
          end
        end else if (r_idx < c_fc) begin
          r_idx <= r_idx + 1'b1;
        end
      end

      if (r_state == c_st_wait_train && class_gen_done)
        r_train_cnt <= w_train_nx;

      if (r_state == c_st_wait_inf && checking_inference) begin
        r_test_cnt <= w_test_nx;
        if (class_inference == r_label && r_correct != '1)
          r_correct <= r_correct + 1'b1;
      end

      if (r_state == c_st_bin_wait) r_bin_cnt <= r_bin_cnt + 1'b1;
      else                          r_bin_cnt <= '0;

      if (r_state == c_st_bin_wait && w_state_nx == c_st_load) r_test_phase <= 1'b1;
      if (r_state == c_st_train_end) r_train_fin <= 1'b1;
      if (r_state == c_st_finish)    r_test_fin  <= 1'b1;
    end
  end

  for (genvar g = 0; g < FEATURE_COUNT; g++) begin : g_pack
    assign input_values[g*WORD_W +: WORD_W] = r_vals[g];
  end

  assign class_select_bits = r_class_sel;
  assign correct_count     = r_correct;
  assign label_err         = r_label_err;
  assign len_err           = r_len_err;

endmodule
`default_nettype wire

// File: tb/tb_hdc_dataset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hdc_dataset_sequencer
// Brief    : Directed self-checking bench for hdc_dataset_sequencer; the bench
//            plays both the dataset source and the HDC top.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hdc_dataset_sequencer;
  localparam int FC = 617;
  localparam int WW = 16;
  localparam int CW = 5;
  localparam int NW = 16;

  logic            clk = 1'b0;
  logic            nrst = 1'b1;
  logic            go = 1'b0;
  logic [NW-1:0]   n_train = '0;
  logic [NW-1:0]   n_test = '0;
  logic            start_hdc, start_mapping, start_binarizing;
  logic [WW*FC-1:0] input_values;
  logic [CW-1:0]   class_select_bits;
  logic            training_dataset_finished, testing_dataset_finished;
  logic            class_gen_done = 1'b0;
  logic            checking_inference = 1'b0;
  logic [CW-1:0]   class_inference = '0;
  logic            oneshot_hdc_done = 1'b0;
  logic            busy, done, label_err, len_err;
  logic [NW-1:0]   correct_count;
`ifdef HDC_SEQ_TIMEOUT_EN
  logic            timeout_err;
`endif

  always #5 clk = ~clk;

  hdc_dataset_sequencer_if #(.WORD_W(WW), .CLASS_W(CW)) strm ();

  hdc_dataset_sequencer #(
    .FEATURE_COUNT(FC), .WORD_W(WW), .CLASS_W(CW), .NUM_CLASSES(26),
    .CNT_W(NW), .BIN_WAIT(4)
`ifdef HDC_SEQ_TIMEOUT_EN
    , .TIMEOUT(16)
`endif
  ) dut (
    .clk(clk), .nrst(nrst), .go(go), .n_train(n_train), .n_test(n_test),
    .strm(strm),
    .start_hdc(start_hdc), .start_mapping(start_mapping),
    .input_values(input_values), .class_select_bits(class_select_bits),
    .training_dataset_finished(training_dataset_finished),
    .start_binarizing(start_binarizing),
    .testing_dataset_finished(testing_dataset_finished),
    .class_gen_done(class_gen_done), .checking_inference(checking_inference),
    .class_inference(class_inference), .oneshot_hdc_done(oneshot_hdc_done),
    .busy(busy), .done(done), .correct_count(correct_count),
    .label_err(label_err), .len_err(len_err)
`ifdef HDC_SEQ_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input int k);
    return {16'h0, input_values[k*WW +: WW]};
  endfunction

  // Pulse / timing monitor
  int cyc = 0;
  int n_hdc = 0, n_map = 0, n_bin = 0;
  int t_bin = 0, t_tfin = 0;
  logic tfin_q = 1'b0;
  logic [CW-1:0] map_sel [32];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (start_hdc) n_hdc++;
    if (start_mapping) begin
      if (n_map < 32) map_sel[n_map] = class_select_bits;
      n_map++;
    end
    if (start_binarizing) begin
      n_bin++;
      t_bin = cyc;
    end
    if (testing_dataset_finished && !tfin_q) t_tfin = cyc;
    tfin_q = testing_dataset_finished;
  end

  task automatic do_go(input int ntr, input int nts);
    @(negedge clk);
    n_train = NW'(ntr);
    n_test  = NW'(nts);
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  // Streams nw words base, base+1, ...; returns #1 after the s_last handshake
  task automatic push_sample(input logic [CW-1:0] lab, input int nw, input logic [15:0] base);
    for (int k = 0; k < nw; k++) begin
      int t = 0;
      strm.s_valid = 1'b1;
      strm.s_data  = base + 16'(k);
      strm.s_label = lab;
      strm.s_last  = (k == nw - 1);
      @(negedge clk);
      while (!strm.s_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (!strm.s_ready) chk("s_ready_timeout", 32'(strm.s_ready), 32'd1);
      @(posedge clk); #1;
    end
    strm.s_valid = 1'b0;
    strm.s_last  = 1'b0;
  endtask

  task automatic map_check(input string tag);
    @(negedge clk);
    chk(tag, 32'(start_mapping), 32'd1);
  endtask

  task automatic train_ack();
    @(posedge clk); #1;
    class_gen_done = 1'b1;
    @(posedge clk); #1;
    class_gen_done = 1'b0;
  endtask

  task automatic infer(input logic [CW-1:0] cls);
    @(posedge clk); #1;
    checking_inference = 1'b1;
    class_inference    = cls;
    @(posedge clk); #1;
    checking_inference = 1'b0;
  endtask

  task automatic finish_run(input string tag);
    int t = 0;
    while (!testing_dataset_finished && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_fin"}, 32'(testing_dataset_finished), 32'd1);
    repeat (3) @(negedge clk);
    chk({tag, "_done_held"}, 32'(done), 32'd0);
    oneshot_hdc_done = 1'b1;
    @(posedge clk); #1;
    oneshot_hdc_done = 1'b0;
    @(negedge clk);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  int m0, h0, b0;

  initial begin
    strm.s_valid = 1'b0;
    strm.s_data  = '0;
    strm.s_label = '0;
    strm.s_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1 nrst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(strm.s_ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_vals0", word_at(0), 32'd0);
    chk("rst_correct", 32'(correct_count), 32'd0);

    // Run A: two training samples, one correct test
    m0 = n_map; h0 = n_hdc; b0 = n_bin;
    do_go(2, 1);
    push_sample(5'd3, FC, 16'h1000);
    map_check("a_map0");
    train_ack();
    push_sample(5'd7, FC, 16'h2000);
    map_check("a_map1");
    chk("a_v0", word_at(0), 32'h2000);
    chk("a_v616", word_at(616), 32'h2268);
    train_ack();
    push_sample(5'd7, FC, 16'h3000);
    map_check("a_map2");
    chk("a_train_fin", 32'(training_dataset_finished), 32'd1);
    infer(5'd7);
    finish_run("a");
    chk("a_n_hdc", 32'(n_hdc - h0), 32'd1);
    chk("a_n_map", 32'(n_map - m0), 32'd3);
    chk("a_n_bin", 32'(n_bin - b0), 32'd1);
    chk("a_sel0", 32'(map_sel[m0]), 32'd3);
    chk("a_sel1", 32'(map_sel[m0+1]), 32'd7);
    chk("a_correct", 32'(correct_count), 32'd1);
    chk("a_label_err", 32'(label_err), 32'd0);
    chk("a_len_err", 32'(len_err), 32'd0);

    // Run B: short then long sample, wrong prediction
    do_go(1, 1);
    chk("b_correct_clr", 32'(correct_count), 32'd0);
    chk("b_tfin_clr", 32'(training_dataset_finished), 32'd0);
    push_sample(5'd2, 600, 16'h4000);
    map_check("b_map0");
    chk("b_len_err", 32'(len_err), 32'd1);
    chk("b_v599", word_at(599), 32'h4257);
    chk("b_v600", word_at(600), 32'd0);
    chk("b_v616", word_at(616), 32'd0);
    train_ack();
    push_sample(5'd4, 620, 16'h5000);
    map_check("b_map1");
    chk("b_v0", word_at(0), 32'h5000);
    chk("b_v616", word_at(616), 32'h5268);
    infer(5'd9);
    finish_run("b");
    chk("b_correct", 32'(correct_count), 32'd0);
    chk("b_len_sticky", 32'(len_err), 32'd1);

    // Run C: out-of-range label forwarded, no test phase
    do_go(1, 0);
    chk("c_len_clr", 32'(len_err), 32'd0);
    push_sample(5'd30, FC, 16'h6000);
    map_check("c_map");
    chk("c_sel", 32'(class_select_bits), 32'd30);
    chk("c_label_err", 32'(label_err), 32'd1);
    train_ack();
    finish_run("c");

    // Run D: empty run, BIN_WAIT spacing
    m0 = n_map; b0 = n_bin;
    do_go(0, 0);
    finish_run("d");
    chk("d_n_map", 32'(n_map - m0), 32'd0);
    chk("d_n_bin", 32'(n_bin - b0), 32'd1);
    chk("d_bin_gap", 32'(t_tfin - t_bin), 32'd5);
    chk("d_label_clr", 32'(label_err), 32'd0);

    // Run E: reset while waiting for inference, then a clean pass
    do_go(0, 1);
    push_sample(5'd5, FC, 16'h7000);
    map_check("e_map");
    @(posedge clk); #1;
    nrst = 1'b1;
    @(posedge clk); #1;
    nrst = 1'b0;
    @(negedge clk);
    chk("e_busy", 32'(busy), 32'd0);
    chk("e_ready", 32'(strm.s_ready), 32'd0);
    chk("e_tfin", 32'(training_dataset_finished), 32'd0);
    chk("e_v0", word_at(0), 32'd0);
    chk("e_done", 32'(done), 32'd0);
    do_go(1, 1);
    push_sample(5'd5, FC, 16'h7100);
    map_check("e_map1");
    train_ack();
    push_sample(5'd5, FC, 16'h7200);
    map_check("e_map2");
    infer(5'd5);
    finish_run("e");
    chk("e_correct", 32'(correct_count), 32'd1);

`ifdef HDC_SEQ_TIMEOUT_EN
    do_go(1, 0);
    push_sample(5'd1, FC, 16'h8000);
    map_check("t_map");
    repeat (10) @(negedge clk);
    chk("t_early_done", 32'(done), 32'd0);
    repeat (10) @(negedge clk);
    chk("t_done", 32'(done), 32'd1);
    chk("t_timeout_err", 32'(timeout_err), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
